// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
// The master side requests an operation; the slave side resolves it and reports results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo, ov
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo, ov
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: one difference bit per clock, LSB first, through a
// single full-subtractor cell and a borrow flop. Reports d = a - b - bi, borrow and overflow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic             last;
    logic             dbit;
    logic             br_nx;
    logic [WIDTH:0]   res_cat;

    logic [WIDTH-1:0] d_q;
    logic             bo_q;
    logic             ov_q;
    logic             busy_q;
    logic             done_q;

    // Full-subtractor cell; the concatenation keeps the right shift legal for WIDTH=1.
    always_comb begin
        last    = (cnt == CW'(WIDTH - 1));
        dbit    = sa[0] ^ sb[0] ^ br;
        br_nx   = (~sa[0] & (sb[0] | br)) | (sb[0] & br);
        res_cat = {dbit, res};
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = SHIFT;
            SHIFT:   if (last)      state_nx = DONE;
            DONE:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Results are captured on the edge entering DONE so they are valid with the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            d_q    <= '0;
            bo_q   <= 1'b0;
            ov_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= (state_nx == DONE);
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        br    <= bus.bi;
                        cnt   <= '0;
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1];
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_nx;
                    res <= res_cat[WIDTH:1];
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        d_q  <= res_cat[WIDTH:1];
                        bo_q <= br_nx;
                        ov_q <= (a_msb ^ b_msb) & (dbit ^ a_msb);
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
    assign bus.ov   = ov_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8 and WIDTH=1 against
// an arithmetic reference model (integer subtraction and signed range test).
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned difference/borrow and true signed overflow of a - b - bi.
    function automatic void model(input int w, input int a, input int b, input int bi,
                                  output int d, output int bo, output int ov);
        int diff, sa, sb, sd;
        diff = a - b - bi;
        bo   = (diff < 0) ? 1 : 0;
        d    = diff & ((1 << w) - 1);
        sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        sd   = sa - sb - bi;
        ov   = (sd < -(1 << (w - 1)) || sd > (1 << (w - 1)) - 1) ? 1 : 0;
    endfunction

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        bus8.start = 1'b1;
        bus8.a = a; bus8.b = b; bus8.bi = bi;
        tick();
        bus8.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bi = 1'($urandom);
    endtask

    task automatic wait_done8(output int lat);
        lat = 1;
        while (!bus8.done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi);
        int lat, ed, ebo, eov;
        model(8, int'(a), int'(b), int'(bi), ed, ebo, eov);
        launch8(a, b, bi);
        check({tag, "_busy"}, longint'(bus8.busy), 1);
        wait_done8(lat);
        check({tag, "_lat"}, lat, 9);
        check({tag, "_d"}, longint'(bus8.d), ed);
        check({tag, "_bo"}, longint'(bus8.bo), ebo);
        check({tag, "_ov"}, longint'(bus8.ov), eov);
        tick();
        check({tag, "_done_1cyc"}, longint'(bus8.done), 0);
        check({tag, "_busy_drop"}, longint'(bus8.busy), 0);
        check({tag, "_hold_d"}, longint'(bus8.d), ed);
    endtask

    initial begin
        int ed, ebo, eov, lat, last_done, pulses;
        bit prev_done;
        bus8.start = 0; bus8.a = 0; bus8.b = 0; bus8.bi = 0;
        bus1.start = 0; bus1.a = 0; bus1.b = 0; bus1.bi = 0;
        tick(); tick();
        check("rst_d8", longint'(bus8.d), 0);
        check("rst_flags8", longint'({bus8.busy, bus8.done, bus8.bo, bus8.ov}), 0);
        check("rst_flags1", longint'({bus1.busy, bus1.done, bus1.bo, bus1.ov, bus1.d}), 0);
        rst = 1'b0;
        tick();

        // WIDTH=1 full-subtractor truth table
        for (int i = 0; i < 8; i++) begin
            model(1, (i >> 2) & 1, (i >> 1) & 1, i & 1, ed, ebo, eov);
            bus1.start = 1'b1;
            bus1.a = 1'((i >> 2) & 1); bus1.b = 1'((i >> 1) & 1); bus1.bi = 1'(i & 1);
            tick();
            bus1.start = 1'b0;
            lat = 1;
            while (!bus1.done && lat < 20) begin tick(); lat++; end
            check($sformatf("w1_lat_%0d", i), lat, 2);
            check($sformatf("w1_bo_d_%0d", i), longint'({bus1.bo, bus1.d}), (ebo << 1) | ed);
            check($sformatf("w1_ov_%0d", i), longint'(bus1.ov), eov);
            tick();
        end

        op8("sub_05_03", 8'h05, 8'h03, 1'b0);
        op8("sub_03_05", 8'h03, 8'h05, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b0);
        op8("sub_00_00_bi", 8'h00, 8'h00, 1'b1);
        op8("sub_7f_ff_bi", 8'h7F, 8'hFF, 1'b1);
        for (int i = 0; i < 16; i++)
            op8($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));

        // start pulsed mid-operation must be ignored
        launch8(8'h05, 8'h03, 1'b0);
        tick(); tick();
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h11;
        tick();
        bus8.start = 1'b0;
        lat = 4;
        while (!bus8.done && lat < 40) begin tick(); lat++; end
        check("ign_lat", lat, 9);
        check("ign_d", longint'(bus8.d), 8'h02);
        tick();
        check("ign_busy_drop", longint'(bus8.busy), 0);
        check("ign_no_restart", longint'(bus8.busy), 0);

        // reset mid-operation
        op8("pre_rst", 8'h05, 8'h03, 1'b0);
        launch8(8'h03, 8'h05, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_flags", longint'({bus8.busy, bus8.done, bus8.bo, bus8.ov}), 0);
        check("mid_rst_d", longint'(bus8.d), 0);
        tick();
        check("mid_rst_idle", longint'(bus8.busy), 0);
        op8("post_rst", 8'h9C, 8'h27, 1'b1);

        // start held high: one result every WIDTH+2 cycles
        bus8.start = 1'b1; bus8.a = 8'h05; bus8.b = 8'h03; bus8.bi = 1'b0;
        last_done = -1; pulses = 0; prev_done = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus8.done) begin
                check("b2b_not_double", longint'(prev_done), 0);
                check("b2b_d", longint'(bus8.d), 8'h02);
                if (last_done >= 0) check("b2b_period", c - last_done, 10);
                last_done = c;
                pulses++;
            end
            prev_done = bus8.done;
        end
        bus8.start = 1'b0;
        check("b2b_pulses", pulses, 3);
        for (int c = 0; c < 12; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial full subtractor with a start/done handshake, the inverse operation of the full-adder datapath in the lab set. It latches two WIDTH-bit operands and a borrow-in, then resolves one difference bit per clock LSB-first through a single full-subtractor cell and a borrow flip-flop. It returns the difference, final borrow-out and a signed-overflow flag. It sits beside the adder blocks as the subtract half of the serial arithmetic unit.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  minuend, latched when start is accepted
- b  in  WIDTH  subtrahend, latched when start is accepted
- bi  in  1  borrow-in to bit 0, latched when start is accepted
- busy  out  1  high while in SHIFT or DONE
- done  out  1  one-cycle pulse; results are valid from this cycle
- d  out  WIDTH  difference a − b − bi (mod 2^WIDTH)
- bo  out  1  borrow out of the MSB (1 when a < b + bi, unsigned)
- ov  out  1  two's-complement overflow of the subtraction

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- IDLE, start=1: load shift regs sa←a and sb←b, borrow flop br←bi, bit counter cnt←0, go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, each cycle:
  - diff bit = sa[0] ^ sb[0] ^ br
  - br ← (~sa[0] & (sb[0] | br)) | (sb[0] & br)
  - diff bit enters the MSB of the result shift reg, which shifts right
  - sa and sb shift right; cnt increments
- On the cycle that processes bit WIDTH−1, go to DONE.
- DONE, for one cycle:
  - d ← result reg
  - bo ← br
  - ov ← (a_msb ^ b_msb) & (d_msb ^ a_msb), using the latched operand MSBs
  - done=1, then go to IDLE
- start in SHIFT or DONE is ignored, not queued. Inputs a, b and bi may change freely after acceptance.
- d, bo and ov hold their values until the next DONE overwrites them.
- Width rules:
  - cnt is wide enough to hold WIDTH−1.
  - WIDTH=1 is legal: SHIFT lasts one cycle.
  - ov uses bit WIDTH−1 as the sign bit.

## Timing
- Reset values: d=0, bo=0, ov=0, done=0, busy=0; state=IDLE, cnt=0, br=0.
- rst dominates everything, including mid-SHIFT. The in-progress operation is discarded and the outputs return to their reset values on the next edge.
- Start accepted at edge k:
  - busy=1 in cycles k+1 … k+WIDTH+1
  - SHIFT spans cycles k+1 … k+WIDTH
  - done=1 and results become valid in cycle k+WIDTH+1
- Latency from start edge to done: WIDTH+1 cycles.
- Back-to-back: start held high continuously is accepted again at the first edge after done, i.e. a throughput of one result every WIDTH+2 cycles.
- done is never high for two consecutive cycles.
- busy and done are registered outputs, with no combinational path from inputs.

## Test plan
- WIDTH=1, all 8 combinations of {a,b,bi} applied in turn → {bo,d} matches the full-subtractor truth table (e.g. 0,1,1 → d=0, bo=1; 1,0,0 → d=1, bo=0).
- WIDTH=8:
  - 8'h05 − 8'h03, bi=0 → d=8'h02, bo=0, ov=0; done exactly 9 cycles after the start edge.
  - 8'h03 − 8'h05, bi=0 → d=8'hFE, bo=1, ov=0.
  - 8'h80 − 8'h01 → d=8'h7F, bo=0, ov=1.
  - 8'h00 − 8'h00, bi=1 → d=8'hFF, bo=1, ov=0.
- Start pulsed again 3 cycles into an operation with different operands → ignored. The first result is unchanged and busy drops on schedule.
- Start with 8'h05 − 8'h03 → d=8'h02; then assert rst 4 cycles into a second operation (8'h03 − 8'h05).
  - Next cycle: busy=0, done=0, d=0, bo=0, ov=0, state IDLE.
  - A subsequent start completes correctly.
- Start held high for 30 cycles → done pulses at regular WIDTH+2 intervals, each one cycle wide.
